// File: rtl/float_struct_pkg.sv
// float_struct: shared binary32 field constants and the FPU status code.
// Used by fp_int_to_float (encode direction) and the FPU adder (decode direction).
// No ports; import with float_struct::*.
package float_struct;

    localparam int unsigned FP_W      = 32;
    localparam int unsigned FP_BIAS   = 127;
    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_MANT_W = 23;

    // Status code that goes out alongside every FPU result.
    typedef enum logic [1:0] {
        OK  = 2'b00,
        NAN = 2'b01,
        INF = 2'b10,
        NUL = 2'b11
    } states;

endpackage

// File: rtl/fp_int_to_float_lzc32.sv
// lzc32: combinational 32-bit leading-zero counter.
// Ports:
//   i_val  [31:0] input word
//   o_cnt  [5:0]  number of leading zeros; 32 when i_val is 0
module lzc32 (
    input  logic [31:0] i_val,
    output logic [5:0]  o_cnt
);

    // Walking upward lets the highest set bit make the last assignment.
    always_comb begin
        o_cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (i_val[i]) begin
                o_cnt = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/fp_int_to_float.sv
// fp_int_to_float: 4-stage pipelined int32/uint32 -> binary32 converter,
// round-to-nearest-even. Accepts one operand per cycle, never stalls.
// Ports:
//   clk      clock
//   rst      synchronous reset, active low
//   a        [31:0] integer operand
//   arg_vld  operand valid
//   result   [31:0] packed binary32 value
//   state    [1:0]  float_struct::states code (OK or NUL here)
//   res_vld  result valid, 4 cycles after the matching arg_vld
//   inexact  (only with FP_INT_TO_FLOAT_INEXACT_EN) rounding discarded bits
// Optional feature macro: FP_INT_TO_FLOAT_INEXACT_EN
module fp_int_to_float
    import float_struct::*;
#(
    parameter bit          SIGNED_IN = 1'b1,
    parameter int unsigned LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic        arg_vld,
    output logic [31:0] result,
    output logic [1:0]  state,
`ifdef FP_INT_TO_FLOAT_INEXACT_EN
    output logic        inexact,
`endif
    output logic        res_vld
);

    // The pipeline below has exactly four register stages.
    if (LATENCY != 4) begin : g_latency_chk
        $error("fp_int_to_float: LATENCY must be 4");
    end

    // S1: sign, magnitude, zero flag
    logic        w_sign;
    logic [31:0] w_mag;
    logic        r1_vld, r1_sign, r1_zero;
    logic [31:0] r1_mag;

    assign w_sign = SIGNED_IN ? a[31] : 1'b0;
    // -0x80000000 wraps to 0x80000000, which is the correct magnitude.
    assign w_mag  = w_sign ? 32'(-a) : a;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r1_vld  <= 1'b0;
            r1_sign <= 1'b0;
            r1_zero <= 1'b0;
            r1_mag  <= '0;
        end else begin
            r1_vld  <= arg_vld;
            r1_sign <= w_sign;
            r1_zero <= (a == 32'd0);
            r1_mag  <= w_mag;
        end
    end

    // S2: leading-zero count
    logic [5:0]  w_lz;
    logic        r2_vld, r2_sign, r2_zero;
    logic [31:0] r2_mag;
    logic [5:0]  r2_lz;

    lzc32 u_lzc (
        .i_val (r1_mag),
        .o_cnt (w_lz)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r2_vld  <= 1'b0;
            r2_sign <= 1'b0;
            r2_zero <= 1'b0;
            r2_mag  <= '0;
            r2_lz   <= '0;
        end else begin
            r2_vld  <= r1_vld;
            r2_sign <= r1_sign;
            r2_zero <= r1_zero;
            r2_mag  <= r1_mag;
            r2_lz   <= w_lz;
        end
    end

    // S3: normalise; the implicit leading one (bit 31) is dropped.
    logic [30:0] w_norm;
    logic [7:0]  w_exp;
    logic        r3_vld, r3_sign, r3_zero;
    logic [30:0] r3_norm;
    logic [7:0]  r3_exp;

    assign w_norm = 31'(r2_mag << r2_lz);
    assign w_exp  = 8'(32'(FP_BIAS) + 32'd31 - 32'(r2_lz));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r3_vld  <= 1'b0;
            r3_sign <= 1'b0;
            r3_zero <= 1'b0;
            r3_norm <= '0;
            r3_exp  <= '0;
        end else begin
            r3_vld  <= r2_vld;
            r3_sign <= r2_sign;
            r3_zero <= r2_zero;
            r3_norm <= w_norm;
            r3_exp  <= w_exp;
        end
    end

    // S4: round to nearest even and pack
    logic        w_guard, w_sticky, w_round_up;
    logic [23:0] w_m_rnd;
    logic [7:0]  w_exp_rnd;
    logic [31:0] w_packed;

    assign w_guard    = r3_norm[7];
    assign w_sticky   = |r3_norm[6:0];
    assign w_round_up = w_guard & (w_sticky | r3_norm[8]);
    // Carry out of the 23-bit mantissa bumps the exponent; exp tops out at 159.
    assign w_m_rnd    = {1'b0, r3_norm[30:8]} + 24'(w_round_up);
    assign w_exp_rnd  = r3_exp + 8'(w_m_rnd[23]);
    assign w_packed   = {r3_sign, w_exp_rnd, w_m_rnd[FP_MANT_W-1:0]};

    logic        r_res_vld;
    logic [31:0] r_result;
    states       r_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_res_vld <= 1'b0;
            r_result  <= '0;
            r_state   <= OK;
        end else begin
            r_res_vld <= r3_vld;
            r_result  <= r3_zero ? 32'd0 : w_packed;
            r_state   <= r3_zero ? NUL : OK;
        end
    end

    assign res_vld = r_res_vld;
    assign result  = r_result;
    assign state   = r_state;

`ifdef FP_INT_TO_FLOAT_INEXACT_EN
    logic r_inexact;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inexact <= 1'b0;
        end else begin
            r_inexact <= r3_zero ? 1'b0 : (w_guard | w_sticky);
        end
    end

    assign inexact = r_inexact;
`endif

endmodule

// File: tb/tb_fp_int_to_float.sv
// Directed bench for fp_int_to_float: one signed and one unsigned instance
// share the stimulus; expected values are hand-computed constants.
module tb_fp_int_to_float;
    import float_struct::*;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic        arg_vld;
    logic [31:0] res_s, res_u;
    logic [1:0]  st_s, st_u;
    logic        vld_s, vld_u;
`ifdef FP_INT_TO_FLOAT_INEXACT_EN
    logic        inx_s, inx_u;
`endif

    int n_vec;
    int n_err;

    fp_int_to_float #(.SIGNED_IN(1'b1), .LATENCY(4)) u_dut_s (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .arg_vld (arg_vld),
        .result  (res_s),
        .state   (st_s),
`ifdef FP_INT_TO_FLOAT_INEXACT_EN
        .inexact (inx_s),
`endif
        .res_vld (vld_s)
    );

    fp_int_to_float #(.SIGNED_IN(1'b0), .LATENCY(4)) u_dut_u (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .arg_vld (arg_vld),
        .result  (res_u),
        .state   (st_u),
`ifdef FP_INT_TO_FLOAT_INEXACT_EN
        .inexact (inx_u),
`endif
        .res_vld (vld_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated operand: res_vld must stay low 3 cycles, rise on the 4th,
    // then drop again.
    task automatic one_op(input string tag, input logic [31:0] val,
                          input logic [31:0] exp_s, input logic [1:0] est_s,
                          input logic [31:0] exp_u, input logic [1:0] est_u,
                          input logic ein_s, input logic ein_u);
        a       = val;
        arg_vld = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            arg_vld = 1'b0;
            if (i < 4) begin
                chk({tag, ".vld_early"}, 32'(vld_s), 32'd0);
            end else if (i == 4) begin
                chk({tag, ".vld_s"}, 32'(vld_s), 32'd1);
                chk({tag, ".vld_u"}, 32'(vld_u), 32'd1);
                chk({tag, ".res_s"}, res_s, exp_s);
                chk({tag, ".st_s"},  32'(st_s), 32'(est_s));
                chk({tag, ".res_u"}, res_u, exp_u);
                chk({tag, ".st_u"},  32'(st_u), 32'(est_u));
`ifdef FP_INT_TO_FLOAT_INEXACT_EN
                chk({tag, ".inx_s"}, 32'(inx_s), 32'(ein_s));
                chk({tag, ".inx_u"}, 32'(inx_u), 32'(ein_u));
`endif
            end else begin
                chk({tag, ".vld_after"}, 32'(vld_s), 32'd0);
            end
        end
        if (ein_s && ein_u && 1'b0) n_vec++;  // keeps args referenced when feature is off
    endtask

    // Streaming tables: 8 valid, 2 idle, 3 valid.
    localparam int unsigned N_STR = 13;
    logic [N_STR-1:0] str_pat;
    logic [31:0] str_a     [N_STR];
    logic [31:0] str_exp_s [N_STR];
    logic [31:0] str_exp_u [N_STR];
    logic [1:0]  str_st    [N_STR];

    initial begin
        int rd;
        n_vec   = 0;
        n_err   = 0;
        a       = '0;
        arg_vld = 1'b0;
        rst     = 1'b0;

        // Reset state
        step();
        step();
        chk("rst.vld_s", 32'(vld_s), 32'd0);
        chk("rst.res_s", res_s, 32'd0);
        chk("rst.st_s",  32'(st_s), 32'(OK));
        rst = 1'b1;
        step();

        // Directed single operands (signed result/state, unsigned result/state, inexact s/u)
        one_op("one",     32'h0000_0001, 32'h3F80_0000, 2'b00, 32'h3F80_0000, 2'b00, 1'b0, 1'b0);
        one_op("m_one",   32'hFFFF_FFFF, 32'hBF80_0000, 2'b00, 32'h4F80_0000, 2'b00, 1'b0, 1'b1);
        one_op("zero",    32'h0000_0000, 32'h0000_0000, 2'b11, 32'h0000_0000, 2'b11, 1'b0, 1'b0);
        one_op("minint",  32'h8000_0000, 32'hCF00_0000, 2'b00, 32'h4F00_0000, 2'b00, 1'b0, 1'b0);
        one_op("tie_even",32'd16777217,  32'h4B80_0000, 2'b00, 32'h4B80_0000, 2'b00, 1'b1, 1'b1);
        one_op("tie_up",  32'd16777219,  32'h4B80_0002, 2'b00, 32'h4B80_0002, 2'b00, 1'b1, 1'b1);
        one_op("maxint",  32'h7FFF_FFFF, 32'h4F00_0000, 2'b00, 32'h4F00_0000, 2'b00, 1'b1, 1'b1);
        one_op("m_two",   32'hFFFF_FFFE, 32'hC000_0000, 2'b00, 32'h4F80_0000, 2'b00, 1'b0, 1'b1);
        one_op("v12345",  32'd12345,     32'h4640_E400, 2'b00, 32'h4640_E400, 2'b00, 1'b0, 1'b0);

        // Streaming
        str_pat = 13'b1_1100_1111_1111;  // bit t = arg_vld in cycle t
        str_a[0]  = 32'h0000_0001; str_exp_s[0]  = 32'h3F80_0000; str_exp_u[0]  = 32'h3F80_0000; str_st[0]  = 2'b00;
        str_a[1]  = 32'hFFFF_FFFF; str_exp_s[1]  = 32'hBF80_0000; str_exp_u[1]  = 32'h4F80_0000; str_st[1]  = 2'b00;
        str_a[2]  = 32'h0000_0000; str_exp_s[2]  = 32'h0000_0000; str_exp_u[2]  = 32'h0000_0000; str_st[2]  = 2'b11;
        str_a[3]  = 32'h8000_0000; str_exp_s[3]  = 32'hCF00_0000; str_exp_u[3]  = 32'h4F00_0000; str_st[3]  = 2'b00;
        str_a[4]  = 32'd16777217;  str_exp_s[4]  = 32'h4B80_0000; str_exp_u[4]  = 32'h4B80_0000; str_st[4]  = 2'b00;
        str_a[5]  = 32'd16777219;  str_exp_s[5]  = 32'h4B80_0002; str_exp_u[5]  = 32'h4B80_0002; str_st[5]  = 2'b00;
        str_a[6]  = 32'h7FFF_FFFF; str_exp_s[6]  = 32'h4F00_0000; str_exp_u[6]  = 32'h4F00_0000; str_st[6]  = 2'b00;
        str_a[7]  = 32'd3;         str_exp_s[7]  = 32'h4040_0000; str_exp_u[7]  = 32'h4040_0000; str_st[7]  = 2'b00;
        str_a[8]  = 32'd7;         str_exp_s[8]  = 32'h0;         str_exp_u[8]  = 32'h0;         str_st[8]  = 2'b00;
        str_a[9]  = 32'd9;         str_exp_s[9]  = 32'h0;         str_exp_u[9]  = 32'h0;         str_st[9]  = 2'b00;
        str_a[10] = 32'hFFFF_FFFE; str_exp_s[10] = 32'hC000_0000; str_exp_u[10] = 32'h4F80_0000; str_st[10] = 2'b00;
        str_a[11] = 32'd10;        str_exp_s[11] = 32'h4120_0000; str_exp_u[11] = 32'h4120_0000; str_st[11] = 2'b00;
        str_a[12] = 32'd12345;     str_exp_s[12] = 32'h4640_E400; str_exp_u[12] = 32'h4640_E400; str_st[12] = 2'b00;

        rd = 0;
        for (int t = 0; t < int'(N_STR) + 5; t++) begin
            logic exp_vld;
            exp_vld = (t >= 4 && t - 4 < int'(N_STR)) ? str_pat[t-4] : 1'b0;
            chk("str.vld_s", 32'(vld_s), 32'(exp_vld));
            chk("str.vld_u", 32'(vld_u), 32'(exp_vld));
            if (exp_vld) begin
                // Idle slots carry data but are skipped: results must stay in order.
                while (!str_pat[rd]) rd++;
                chk("str.res_s", res_s, str_exp_s[rd]);
                chk("str.res_u", res_u, str_exp_u[rd]);
                chk("str.st_s",  32'(st_s), 32'(str_st[rd]));
                rd++;
            end
            if (t < int'(N_STR)) begin
                a       = str_a[t];
                arg_vld = str_pat[t];
            end else begin
                arg_vld = 1'b0;
            end
            step();
        end

        // Reset with three operands in flight
        for (int i = 0; i < 3; i++) begin
            a       = 32'd100 + 32'(i);
            arg_vld = 1'b1;
            step();
        end
        arg_vld = 1'b0;
        rst     = 1'b0;
        step();
        chk("rstf.vld_s", 32'(vld_s), 32'd0);
        chk("rstf.res_s", res_s, 32'd0);
        chk("rstf.st_s",  32'(st_s), 32'(OK));
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rstf.no_vld", 32'(vld_s | vld_u), 32'd0);
        end
        one_op("post_rst", 32'd10, 32'h4120_0000, 2'b00, 32'h4120_0000, 2'b00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
